// File: rtl/frozen_frame_sched.sv
// Polar-code frozen-bit scheduler.
// The block loads a reliability-ordered index table one entry at a time and
// builds an N-bit information mask from it. It then streams u-vectors one
// position per cycle: information positions take the next data bit, and
// frozen positions emit 0.
//
// Handshakes (tbl_*, in_*, out_*): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holds valid and its payload
// until that transfer occurs. out_* is the only producer side of this block;
// while out_valid && !out_ready, out_bit/out_pos/out_last stay stable.
module frozen_frame_sched #(
  parameter int N = 32,
  parameter int K = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_valid,
  input  logic [$clog2(N):0]     tbl_idx,
  output logic                   tbl_ready,
  output logic                   tbl_err,
  input  logic                   tbl_load,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic [$clog2(N)-1:0]   out_pos,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [15:0]            frame_cnt
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_POS        = PW'(N - 1);
  // Ranks at or above this value carry information bits (the K most reliable).
  localparam logic [PW-1:0] FIRST_INFO_RANK = PW'(N - K);

  typedef enum logic [0:0] {
    S_TBL = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [N-1:0]    used_q, used_d;
  logic [PW-1:0]   rank_q, rank_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic            tbl_err_q, tbl_err_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic [PW-1:0]   out_pos_q, out_pos_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic [PW-1:0]   idx_lo;
  logic            idx_oob;
  logic            tbl_accept;
  logic            tbl_bad;
  logic            slot_free;
  logic            info_pos;
  logic            reload;
  logic            advance;

  // With N a power of two, the index MSB alone flags idx >= N.
  assign idx_lo     = tbl_idx[PW-1:0];
  assign idx_oob    = tbl_idx[PW];
  assign tbl_ready  = (state_q == S_TBL);
  assign tbl_accept = tbl_valid && tbl_ready;
  assign tbl_bad    = idx_oob || used_q[idx_lo];

  // The output register can take a new position when empty or being drained.
  assign slot_free  = !out_valid_q || out_ready;
  assign info_pos   = mask_q[pos_q];

  // A reload is only taken at a frame boundary and beats a same-cycle advance.
  assign reload     = (state_q == S_RUN) && tbl_load && (pos_q == '0) && slot_free;
  assign advance    = (state_q == S_RUN) && slot_free && !reload &&
                      (!info_pos || in_valid);

  // in_ready is dropped during a reload so a source never sees a bit
  // accepted that the frame will not carry.
  assign in_ready   = (state_q == S_RUN) && slot_free && info_pos && !reload;

  assign tbl_err    = tbl_err_q;
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_pos    = out_pos_q;
  assign out_last   = out_last_q;
  assign frame_cnt  = frame_cnt_q;

  // Next-state logic for table loading, frame streaming and frame counting.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    used_d      = used_q;
    rank_d      = rank_q;
    pos_d       = pos_q;
    tbl_err_d   = tbl_err_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_pos_d   = out_pos_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;

    if (out_valid_q && out_ready && out_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    case (state_q)
      S_TBL: begin
        if (tbl_accept) begin
          if (tbl_bad) begin
            // Duplicate or out-of-range index: discard the partial table.
            tbl_err_d = 1'b1;
            rank_d    = '0;
            used_d    = '0;
            mask_d    = '0;
          end else begin
            used_d[idx_lo] = 1'b1;
            mask_d[idx_lo] = (rank_q >= FIRST_INFO_RANK);
            if (rank_q == LAST_POS) begin
              state_d   = S_RUN;
              rank_d    = '0;
              pos_d     = '0;
              tbl_err_d = 1'b0;
            end else begin
              rank_d = rank_q + PW'(1);
            end
          end
        end
      end

      S_RUN: begin
        if (reload) begin
          state_d     = S_TBL;
          rank_d      = '0;
          used_d      = '0;
          mask_d      = '0;
          out_valid_d = 1'b0;
        end else if (advance) begin
          out_bit_d   = info_pos ? in_bit : 1'b0;
          out_pos_d   = pos_q;
          out_last_d  = (pos_q == LAST_POS);
          out_valid_d = 1'b1;
          pos_d       = (pos_q == LAST_POS) ? '0 : pos_q + PW'(1);
        end else if (slot_free) begin
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_TBL;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_TBL;
      mask_q      <= '0;
      used_q      <= '0;
      rank_q      <= '0;
      pos_q       <= '0;
      tbl_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_pos_q   <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      used_q      <= used_d;
      rank_q      <= rank_d;
      pos_q       <= pos_d;
      tbl_err_q   <= tbl_err_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_pos_q   <= out_pos_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
